serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_pkg.sv | 15 +
 rtl/serial_add_ctrl_fa.sv | 17 +
 rtl/serial_add_ctrl.sv | 124 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   state_t      : controller FSM encoding (IDLE, RUN, DONE)
//   MIN_N/MAX_N  : legal operand-width range, checked at elaboration
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_N = 2;
  localparam int MAX_N = 32;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell, shared across time by the serial sequencer.
// Ports:
//   C, B, A : carry-in and the two operand bits
//   Sum     : A ^ B ^ C
//   Carry   : majority(A, B, C)
module serial_add_ctrl_fa (
  input  logic C,
  input  logic B,
  input  logic A,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (A & C) | (B & C);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer around a single full-adder cell.
// Operands are captured on start and fed LSB-first, one bit per clock.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   start      : request, sampled only in IDLE
//   sub        : 0 = A+B, 1 = A-B (sampled with start)
//   a_in, b_in : N-bit operands (sampled with start)
//   busy       : high in RUN and DONE
//   done       : one-cycle pulse, result valid from this cycle on
//   result     : N-bit sum/difference, held until next accepted start
//   cout       : final carry (subtract: 1 = no borrow)
//   ovf        : two's-complement overflow
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf
);

  generate
    if (N < MIN_N || N > MAX_N) begin : g_bad_width
      $error("serial_add_ctrl: N out of range");
    end
  endgenerate

  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [CW-1:0] MSB_CIN  = CW'(N - 2);

  state_t         state_reg, state_next;
  logic [N-1:0]   a_sh_reg, b_sh_reg, result_reg;
  logic [CW-1:0]  cnt_reg;
  logic           cy_reg, cy_msb_reg, cout_reg, ovf_reg;
  logic           fa_sum, fa_carry;

  serial_add_ctrl_fa u_fa (
    .C     (cy_reg),
    .B     (b_sh_reg[0]),
    .A     (a_sh_reg[0]),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      result_reg <= '0;
      cnt_reg    <= '0;
      cy_reg     <= 1'b0;
      cy_msb_reg <= 1'b0;
      cout_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg <= a_in;
            // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
            b_sh_reg <= sub ? ~b_in : b_in;
            cy_reg   <= sub;
            cnt_reg  <= '0;
          end
        end
        RUN: begin
          // Sum enters at the MSB so the finished word lands LSB-aligned.
          result_reg <= {fa_sum, result_reg[N-1:1]};
          a_sh_reg   <= a_sh_reg >> 1;
          b_sh_reg   <= b_sh_reg >> 1;
          cy_reg     <= fa_carry;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == MSB_CIN) begin
            cy_msb_reg <= fa_carry;
          end
          if (cnt_reg == LAST_BIT) begin
            cout_reg <= fa_carry;
            // Overflow: carry into MSB differs from carry out of MSB.
            ovf_reg  <= cy_msb_reg ^ fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_reg == LAST_BIT) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign result = result_reg;
  assign cout   = cout_reg;
  assign ovf    = ovf_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (N=8): directed vectors with
// hand-computed results, scoreboard queue filled at acceptance and
// drained by a monitor on every done pulse.
module tb_serial_add_ctrl;

  localparam int N = 8;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       v;
  } exp_t;

  typedef struct packed {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a_in = '0;
  logic [N-1:0] b_in = '0;
  logic         busy, done, cout, ovf;
  logic [N-1:0] result;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_add_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .sub    (sub),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("done: result=%02h cout=%0b ovf=%0b (want %02h %0b %0b)",
                 result, cout, ovf, e.res, e.c, e.v);
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.c));
        chk("ovf", 32'(ovf), 32'(e.v));
      end
    end
  end

  // Counts edges until done is seen (sampled 1ns after each edge), bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!done && !busy) break;
    end while (!done && n < 40);
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done after %0d edges expected done", n);
    end
  endtask

  // Issue one operation, check busy through RUN and done latency (8 edges).
  task automatic run_op(input vec_t v, input bit check_timing);
    int n;
    @(negedge clk);
    start = 1'b1; sub = v.sub; a_in = v.a; b_in = v.b;
    @(posedge clk);
    sb_q.push_back('{res: v.res, c: v.c, v: v.v});
    $display("op: sub=%0b a=%02h b=%02h", v.sub, v.a, v.b);
    #1 start = 1'b0;
    if (check_timing) chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(n);
    if (check_timing) chk("done_latency", 32'(n), 32'd8);
    @(posedge clk);
    #1;
    if (check_timing) chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t b2b[4];

  initial begin
    int n;
    vecs[0] = '{sub:0, a:8'h35, b:8'h4A, res:8'h7F, c:0, v:0};
    vecs[1] = '{sub:0, a:8'hFF, b:8'h01, res:8'h00, c:1, v:0};
    vecs[2] = '{sub:0, a:8'h7F, b:8'h01, res:8'h80, c:0, v:1};
    vecs[3] = '{sub:0, a:8'h80, b:8'hFF, res:8'h7F, c:1, v:1};
    vecs[4] = '{sub:1, a:8'h10, b:8'h20, res:8'hF0, c:0, v:0};
    vecs[5] = '{sub:1, a:8'h20, b:8'h10, res:8'h10, c:1, v:0};
    b2b[0]  = '{sub:0, a:8'h05, b:8'h03, res:8'h08, c:0, v:0};
    b2b[1]  = '{sub:1, a:8'h03, b:8'h05, res:8'hFE, c:0, v:0};
    b2b[2]  = '{sub:0, a:8'h40, b:8'h40, res:8'h80, c:0, v:1};
    b2b[3]  = '{sub:1, a:8'h80, b:8'h01, res:8'h7F, c:1, v:1};

    // Reset state.
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed add/subtract vectors.
    for (int i = 0; i < 6; i++) run_op(vecs[i], 1'b1);

    // Start pulsed during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a_in = 8'h12; b_in = 8'h34;
    @(posedge clk);
    sb_q.push_back('{res: 8'h46, c: 1'b0, v: 1'b0});
    $display("op: sub=0 a=12 b=34 (with stray start during RUN)");
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; a_in = 8'hAA; b_in = 8'h55; sub = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (3) @(posedge clk);

    // Reset mid-RUN after bit 4: abort, no done pulse.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a_in = 8'h55; b_in = 8'h0F;
    @(posedge clk);
    $display("op: sub=0 a=55 b=0F (aborted by reset)");
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 chk("abort_no_done", 32'(done), 32'd0);
    run_op('{sub:0, a:8'h01, b:8'h02, res:8'h03, c:0, v:0}, 1'b1);

    // Back-to-back with start held high: each op accepted 10 cycles apart.
    @(negedge clk);
    start = 1'b1; sub = b2b[0].sub; a_in = b2b[0].a; b_in = b2b[0].b;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      sb_q.push_back('{res: b2b[i].res, c: b2b[i].c, v: b2b[i].v});
      $display("op: sub=%0b a=%02h b=%02h (back-to-back)", b2b[i].sub, b2b[i].a, b2b[i].b);
      #1;
      if (i < 3) begin
        sub = b2b[i+1].sub; a_in = b2b[i+1].a; b_in = b2b[i+1].b;
      end else begin
        start = 1'b0;
      end
      wait_done(n);
      chk("b2b_latency", 32'(n), 32'd8);
      @(posedge clk);
      #1 chk("b2b_idle_gap", 32'(busy), 32'd0);
    end

    repeat (4) @(posedge clk);
    #1 chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
